// File: rtl/window_3x3_streamer_pkg.sv
// Shared definitions for the 3x3 window streamer, line buffer and conv stage:
// FSM encoding, default geometry, index widths and window tap ordering.
package window_3x3_streamer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam int unsigned DEF_DATA_BITS = 8;
    localparam int unsigned DEF_H         = 24;
    localparam int unsigned DEF_W         = 24;
    localparam int unsigned DEF_K         = 6;

    localparam int unsigned COL_W = $clog2(DEF_W);
    localparam int unsigned ROW_W = $clog2(DEF_H);

    // Window taps are row-major: tap = r*3 + dx, r=0 is the top row, dx=0 the leftmost pixel.
    localparam int unsigned TAP_ROWS = 3;
    localparam int unsigned TAP_COLS = 3;
    localparam int unsigned NUM_TAPS = TAP_ROWS * TAP_COLS;

    function automatic int unsigned tap_index(input int unsigned r, input int unsigned dx);
        return r * TAP_COLS + dx;
    endfunction

endpackage

// File: rtl/window_3x3_streamer_if.sv
// Row-triplet input and window output bundle of the 3x3 window streamer.
interface window_3x3_streamer_if
    import window_3x3_streamer_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEF_DATA_BITS,
    parameter int unsigned H         = DEF_H,
    parameter int unsigned W         = DEF_W,
    parameter int unsigned K         = DEF_K
) ();
    logic [W*K*DATA_BITS-1:0]        row_1;
    logic [W*K*DATA_BITS-1:0]        row_2;
    logic [W*K*DATA_BITS-1:0]        row_3;
    logic                            valid_i;
    logic                            ready_o;
    logic [NUM_TAPS*K*DATA_BITS-1:0] window_o;
    logic [$clog2(W)-1:0]            col_o;
    logic [$clog2(H)-1:0]            row_o;
    logic                            valid_o;
    logic                            ready_i;
    logic                            last_o;
    logic                            frame_last_o;

    modport slave (
        input  row_1, row_2, row_3, valid_i, ready_i,
        output ready_o, window_o, col_o, row_o, valid_o, last_o, frame_last_o
    );

    modport master (
        output row_1, row_2, row_3, valid_i, ready_i,
        input  ready_o, window_o, col_o, row_o, valid_o, last_o, frame_last_o
    );
endinterface

// File: rtl/window_3x3_streamer_tap_mux.sv
// Combinational 3x3xK tap selection from the three stored rows at centre column i_col.
// WINDOW_ZERO_PAD_EN: taps left of pixel 0 or right of pixel W-1 read as zero.
module window_tap_mux
    import window_3x3_streamer_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEF_DATA_BITS,
    parameter int unsigned W         = DEF_W,
    parameter int unsigned K         = DEF_K
) (
    input  logic [W*K*DATA_BITS-1:0]        i_row_1,
    input  logic [W*K*DATA_BITS-1:0]        i_row_2,
    input  logic [W*K*DATA_BITS-1:0]        i_row_3,
    input  logic [$clog2(W)-1:0]            i_col,
    output logic [NUM_TAPS*K*DATA_BITS-1:0] o_window
);
    localparam int unsigned PIX_BITS = K * DATA_BITS;
    localparam int unsigned CW       = $clog2(W);

    logic [PIX_BITS-1:0] w_pix [TAP_ROWS][W];

    for (genvar x = 0; x < W; x++) begin : g_pix
        assign w_pix[0][x] = i_row_1[x*PIX_BITS +: PIX_BITS];
        assign w_pix[1][x] = i_row_2[x*PIX_BITS +: PIX_BITS];
        assign w_pix[2][x] = i_row_3[x*PIX_BITS +: PIX_BITS];
    end

    // A pixel's K channels are contiguous in both row and window layouts, so each tap is one pixel copy.
    for (genvar r = 0; r < TAP_ROWS; r++) begin : g_row
        for (genvar dx = 0; dx < TAP_COLS; dx++) begin : g_dx
            localparam int unsigned TAP = tap_index(r, dx);
`ifdef WINDOW_ZERO_PAD_EN
            localparam int unsigned XW = CW + 1;
            logic [XW-1:0] w_xp1;
            assign w_xp1 = {1'b0, i_col} + XW'(dx);
            assign o_window[TAP*PIX_BITS +: PIX_BITS] =
                (w_xp1 != '0 && w_xp1 <= XW'(W)) ? w_pix[r][CW'(w_xp1 - XW'(1))] : '0;
`else
            assign o_window[TAP*PIX_BITS +: PIX_BITS] = w_pix[r][i_col + CW'(dx) - CW'(1)];
`endif
        end
    end

endmodule

// File: rtl/window_3x3_streamer.sv
// Consumes aligned row triplets and streams 3x3xK windows left to right under ready/valid.
// WINDOW_ZERO_PAD_EN: horizontal zero padding, W windows per triplet instead of W-2.
module window_3x3_streamer
    import window_3x3_streamer_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEF_DATA_BITS,
    parameter int unsigned H         = DEF_H,
    parameter int unsigned W         = DEF_W,
    parameter int unsigned K         = DEF_K
) (
    input  logic                 clk,
    input  logic                 reset,
    window_3x3_streamer_if.slave bus
);
    localparam int unsigned ROW_BITS = W * K * DATA_BITS;
    localparam int unsigned CW       = $clog2(W);
    localparam int unsigned RW       = $clog2(H);
`ifdef WINDOW_ZERO_PAD_EN
    localparam int unsigned FIRST_COL = 0;
    localparam int unsigned LAST_COL  = W - 1;
`else
    localparam int unsigned FIRST_COL = 1;
    localparam int unsigned LAST_COL  = W - 2;
`endif

    state_t                             r_state;
    logic [CW-1:0]                      r_col;
    logic [RW-1:0]                      r_row;
    logic [ROW_BITS-1:0]                r_row_1;
    logic [ROW_BITS-1:0]                r_row_2;
    logic [ROW_BITS-1:0]                r_row_3;

    logic                               w_stream;
    logic                               w_last;
    logic                               w_done;
    logic                               w_accept;
    logic [NUM_TAPS*K*DATA_BITS-1:0]    w_window;

    assign w_stream = (r_state == ST_STREAM);
    assign w_last   = w_stream && (r_col == CW'(LAST_COL));
    assign w_done   = w_last && bus.ready_i;
    // A new triplet is taken while idle or on the very cycle the last window is consumed.
    assign w_accept = bus.valid_i && (!w_stream || w_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_row_1 <= '0;
            r_row_2 <= '0;
            r_row_3 <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.valid_i) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (bus.ready_i && !w_last) begin
                        r_col <= r_col + CW'(1);
                    end
                    if (w_done) begin
                        r_row <= (r_row == RW'(H - 3)) ? '0 : r_row + RW'(1);
                        if (!bus.valid_i) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_accept) begin
                r_row_1 <= bus.row_1;
                r_row_2 <= bus.row_2;
                r_row_3 <= bus.row_3;
                r_col   <= CW'(FIRST_COL);
            end
        end
    end

    window_tap_mux #(
        .DATA_BITS (DATA_BITS),
        .W         (W),
        .K         (K)
    ) u_tap_mux (
        .i_row_1  (r_row_1),
        .i_row_2  (r_row_2),
        .i_row_3  (r_row_3),
        .i_col    (r_col),
        .o_window (w_window)
    );

    assign bus.window_o     = w_window;
    assign bus.col_o        = r_col;
    assign bus.row_o        = r_row;
    assign bus.valid_o      = w_stream;
    assign bus.last_o       = w_last;
    assign bus.frame_last_o = w_last && (r_row == RW'(H - 3));
    assign bus.ready_o      = !w_stream || w_done;

endmodule

// File: tb/tb_window_3x3_streamer.sv
// Directed bench for window_3x3_streamer: reset, tap table, backpressure, back-to-back, frame wrap, mid-stream reset.
module tb_window_3x3_streamer;
    import window_3x3_streamer_pkg::*;

    localparam int DB = 8;
    localparam int H  = 24;
    localparam int W  = 24;
    localparam int K  = 6;
    localparam int RB = W * K * DB;
    localparam int WB = 9 * K * DB;
`ifdef WINDOW_ZERO_PAD_EN
    localparam int FIRST = 0;
    localparam int LAST  = W - 1;
`else
    localparam int FIRST = 1;
    localparam int LAST  = W - 2;
`endif
    localparam int NWIN = LAST - FIRST + 1;

    typedef struct {
        int col;
        int r;
        int dx;
        int exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    window_3x3_streamer_if #(.DATA_BITS(DB), .H(H), .W(W), .K(K)) bus ();

    window_3x3_streamer #(.DATA_BITS(DB), .H(H), .W(W), .K(K)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_hs    = 0;
    int n_fl    = 0;
    int m_col;
    int m_row;
    vec_t vecs [8];
    logic [RB-1:0] rows_t [3];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    endtask

    function automatic int tap(input logic [WB-1:0] w, input int r, input int dx, input int c);
        logic [WB-1:0] s;
        s = w >> (((r * 3 + dx) * K + c) * DB);
        return int'(s[DB-1:0]);
    endfunction

    // Reference stream model: checks every consumed window in order.
    initial begin
        m_col = FIRST;
        m_row = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_col = FIRST;
                m_row = 0;
            end else if (bus.valid_o && bus.ready_i) begin
                chk("mon_col", int'(bus.col_o), m_col);
                chk("mon_row", int'(bus.row_o), m_row);
                chk("mon_last", int'(bus.last_o), int'(m_col == LAST));
                chk("mon_frame_last", int'(bus.frame_last_o), int'(m_col == LAST && m_row == H - 3));
                chk("mon_centre_tap", tap(bus.window_o, 1, 1, K - 1), 128 + m_col);
                n_hs++;
                if (bus.frame_last_o) n_fl++;
                if (m_col == LAST) begin
                    m_col = FIRST;
                    m_row = (m_row == H - 3) ? 0 : m_row + 1;
                end else begin
                    m_col++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_one();
        bus.valid_i = 1'b1;
        tick();
        bus.valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && bus.valid_o; i++) tick();
        chk("drain_done", int'(bus.valid_o), 0);
    endtask

    task automatic wait_col(input int col);
        for (int i = 0; i < 100 && int'(bus.col_o) != col; i++) tick();
        chk("wait_col", int'(bus.col_o), col);
    endtask

    // Holds valid_i until n triplets are accepted; returns accepts and the longest valid_o run.
    task automatic run_triplets(input int n, output int n_acc, output int run);
        n_acc = 0;
        run = 0;
        bus.valid_i = 1'b1;
        for (int i = 0; i < 100 * n + 100; i++) begin
            if (bus.ready_o && bus.valid_i) begin
                n_acc++;
                if (n_acc > 1) chk("b2b_accept_on_last", int'(bus.last_o), 1);
            end
            tick();
            if (n_acc == n) bus.valid_i = 1'b0;
            if (bus.valid_o) run++;
            else if (run > 0) break;
        end
        bus.valid_i = 1'b0;
    endtask

    initial begin
        int hs0;
        int n_acc;
        int run;
        logic [WB-1:0] saved;

        vecs[0] = '{1, 0, 0, 'h40};
        vecs[1] = '{1, 0, 1, 'h41};
        vecs[2] = '{1, 0, 2, 'h42};
        vecs[3] = '{1, 1, 1, 'h81};
        vecs[4] = '{22, 2, 2, 'hD7};
        vecs[5] = '{22, 0, 0, 'h55};
        vecs[6] = '{10, 1, 0, 'h89};
        vecs[7] = '{15, 2, 1, 'hCF};

        for (int r = 0; r < 3; r++) begin
            rows_t[r] = '0;
            for (int x = 0; x < W; x++)
                for (int c = 0; c < K; c++)
                    rows_t[r] = rows_t[r] | (RB'((r + 1) * 64 + x) << ((x * K + c) * DB));
        end
        bus.row_1   = rows_t[0];
        bus.row_2   = rows_t[1];
        bus.row_3   = rows_t[2];
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;

        // Reset state
        reset = 1'b1;
        repeat (2) tick();
        chk("rst_ready_o", int'(bus.ready_o), 1);
        chk("rst_valid_o", int'(bus.valid_o), 0);
        chk("rst_last_o", int'(bus.last_o), 0);
        chk("rst_frame_last_o", int'(bus.frame_last_o), 0);
        chk("rst_window_zero", int'(bus.window_o == '0), 1);
        chk("rst_col_o", int'(bus.col_o), 0);
        chk("rst_row_o", int'(bus.row_o), 0);
        reset = 1'b0;
        tick();

        // Single triplet with table-driven tap checks
        accept_one();
        for (int k = 0; k < NWIN; k++) begin
            chk("t1_valid_o", int'(bus.valid_o), 1);
            chk("t1_col_o", int'(bus.col_o), FIRST + k);
            chk("t1_last_o", int'(bus.last_o), int'(k == NWIN - 1));
            chk("t1_ready_o", int'(bus.ready_o), int'(k == NWIN - 1));
            for (int i = 0; i < 8; i++)
                if (vecs[i].col == FIRST + k)
                    chk($sformatf("vec%0d_tap", i), tap(bus.window_o, vecs[i].r, vecs[i].dx, i % K), vecs[i].exp);
            tick();
        end
        chk("t1_end_valid_o", int'(bus.valid_o), 0);
        chk("t1_end_ready_o", int'(bus.ready_o), 1);

        // Backpressure at col 7
        hs0 = n_hs;
        accept_one();
        wait_col(7);
        saved = bus.window_o;
        bus.ready_i = 1'b0;
        repeat (5) begin
            tick();
            chk("bp_col_hold", int'(bus.col_o), 7);
            chk("bp_window_hold", int'(bus.window_o == saved), 1);
            chk("bp_valid_o", int'(bus.valid_o), 1);
            chk("bp_ready_o", int'(bus.ready_o), 0);
        end
        bus.ready_i = 1'b1;
        drain();
        chk("bp_handshakes", n_hs - hs0, NWIN);

        // Back-to-back triplets, no bubble
        hs0 = n_hs;
        run_triplets(2, n_acc, run);
        chk("b2b_accepts", n_acc, 2);
        chk("b2b_valid_run", run, 2 * NWIN);
        chk("b2b_handshakes", n_hs - hs0, 2 * NWIN);

        // Complete the frame: 4 triplets done, 18 more
        chk("fw_no_frame_last_yet", n_fl, 0);
        chk("fw_row_before", int'(bus.row_o), 4);
        run_triplets(H - 2 - 4, n_acc, run);
        chk("fw_accepts", n_acc, H - 6);
        chk("fw_frame_last_once", n_fl, 1);
        chk("fw_row_wrapped", int'(bus.row_o), 0);
        accept_one();
        chk("fw_next_row_o", int'(bus.row_o), 0);
        chk("fw_next_col_o", int'(bus.col_o), FIRST);
        drain();
        chk("fw_frame_last_still_once", n_fl, 1);

        // Reset mid-stream at col 10
        accept_one();
        wait_col(10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_valid_o", int'(bus.valid_o), 0);
        chk("mr_ready_o", int'(bus.ready_o), 1);
        chk("mr_row_o", int'(bus.row_o), 0);
        tick();
        chk("mr_still_idle", int'(bus.valid_o), 0);
        accept_one();
        chk("mr_restart_col", int'(bus.col_o), FIRST);
        chk("mr_restart_valid", int'(bus.valid_o), 1);
        drain();

`ifdef WINDOW_ZERO_PAD_EN
        // Padded edges
        hs0 = n_hs;
        accept_one();
        chk("pad_first_col", int'(bus.col_o), 0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < K; c++)
                chk("pad_left_zero", tap(bus.window_o, r, 0, c), 0);
        chk("pad_left_centre", tap(bus.window_o, 1, 1, 0), 'h80);
        wait_col(W - 1);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < K; c++)
                chk("pad_right_zero", tap(bus.window_o, r, 2, c), 0);
        chk("pad_right_dx1", tap(bus.window_o, 2, 1, 0), 192 + W - 1);
        drain();
        chk("pad_handshakes", n_hs - hs0, W);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/window_3x3_streamer.md
Name: window_3x3_streamer

Overview:
- Reader/consumer side of the three-row line-buffer interface.
- Accepts one aligned row triplet (top/mid/bottom, each W pixels × K channels) per handshake and stores it.
- Serializes the triplet into a stream of 3×3×K windows, one per cycle, left to right, under ready/valid backpressure.
- Feeds the downstream conv/MAC stage; tracks row position within a frame and flags the frame's last window.

Parameters:
- DATA_BITS, 8, bits per channel sample
- H, 24, frame height in rows
- W, 24, row width in pixels
- K, 6, channels per pixel

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- row_1  input  W*DATA_BITS*K  top row; pixel x, channel c at bits [(x*K+c)*DATA_BITS +: DATA_BITS]
- row_2  input  W*DATA_BITS*K  middle row, same layout
- row_3  input  W*DATA_BITS*K  bottom row, same layout
- valid_i  input  1  triplet valid
- ready_o  output  1  triplet accepted when valid_i && ready_o
- window_o  output  9*K*DATA_BITS  element (r,dx,c) at bits [((r*3+dx)*K+c)*DATA_BITS +: DATA_BITS]; r=0 is row_1, dx=0 is leftmost
- col_o  output  $clog2(W)  centre pixel x of current window
- row_o  output  $clog2(H)  triplet index within frame
- valid_o  output  1  window valid
- ready_i  input  1  downstream ready; window consumed when valid_o && ready_i
- last_o  output  1  last window of current triplet
- frame_last_o  output  1  last window of last triplet of frame

Behaviour:
- Reset (synchronous, priority over everything):
  - state=IDLE; col, row counters = 0; stored rows cleared to 0.
  - Outputs: ready_o=1, valid_o=0, last_o=0, frame_last_o=0, window_o=0, col_o=0, row_o=0.
  - Reset mid-STREAM abandons the triplet; no further windows are emitted.
- Columns (no padding):
  - Centre x runs 1..W-2, giving W-2 windows per triplet.
  - Window dx=0..2 maps to pixels x-1..x+1.
- FSM IDLE:
  - ready_o=1, valid_o=0.
  - On valid_i: latch row_1..3, col=first centre, go to STREAM.
- FSM STREAM:
  - valid_o=1; window_o is combinational from stored rows and col.
  - ready_o = last_o && ready_i.
  - On ready_i && !last_o: col++.
  - On ready_i && last_o:
    - Triplet done. row = (row==H-3) ? 0 : row+1.
    - If valid_i in the same cycle: latch the new triplet, col=first centre, stay in STREAM (back-to-back, no bubble).
    - Otherwise go to IDLE.
- Latency and hold:
  - First window is valid the cycle after triplet acceptance.
  - Steady throughput is one window per cycle.
  - While ready_i=0, window_o, col_o, last_o and frame_last_o hold stable.
- Flags: last_o = (col==last centre). frame_last_o = last_o && row==H-3.
- Frame size: H-2 triplets per frame; vertical padding is the line buffer's job.
- Inputs are sampled only at the handshake; row_* may change freely otherwise.
- valid_i while STREAM and not at last_o&&ready_i: ignored, not accepted; the upstream holds it.

Optional Feature:
- Macro: WINDOW_ZERO_PAD_EN
- Defined:
  - Horizontal zero padding; centre x runs 0..W-1, giving W windows per triplet.
  - Taps at x=-1 or x=W read as 0.
  - last_o at col==W-1.
- Undefined: behaviour exactly as above (W-2 windows, col 1..W-2); no padding logic synthesized.

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_IDLE, ST_STREAM)
  - index helpers / localparams COL_W=$clog2(W), ROW_W=$clog2(H)
  - window tap ordering constants, also used by the line buffer and conv stage
- One sub-module: window_tap_mux.
  - Combinational; stored rows + col → window_o.
  - Contains the zero-pad selection under WINDOW_ZERO_PAD_EN.
  - Top level holds FSM, counters and row registers.

Test Plan:
Default params; every sample of pixel x in row r set to r*64+x (r=1,2,3), all channels equal.
- Reset then one triplet, ready_i=1:
  - valid_o on cycles 1..22 after accept.
  - First window row_1 taps 0x40,0x41,0x42; centre 0x81; col_o=1.
  - last_o only at col_o=22; then ready_o=1, valid_o=0.
- Backpressure:
  - ready_i=0 for 5 cycles at col_o=7 → window_o/col_o frozen, no window dropped or duplicated.
  - Count exactly 22 distinct handshakes.
- Back-to-back: two triplets with valid_i held → second accepted on the first's last_o&&ready_i cycle; 44 consecutive valid_o cycles, no bubble.
- Frame wrap:
  - 22 triplets → frame_last_o exactly once, on the 22nd triplet's col 22.
  - row_o returns to 0; next triplet has row_o=0.
- Reset at col_o=10 → next cycle valid_o=0, ready_o=1, row_o=0; new triplet restarts at col_o=1.
- With WINDOW_ZERO_PAD_EN:
  - 24 windows per triplet.
  - col_o=0 window has dx=0 taps all 0 and dx=1 row_2 tap 0x80.
  - col_o=23 window has dx=2 taps all 0.
